// File: rtl/fft2_result_serializer_pkg.sv
// rtl/fft2_result_serializer_pkg.sv - shared types, pair-record layout and helpers for the fft2 result serializer
// Contents:
//   DW_DEFAULT    default real/imag word width
//   pair_field_e  field selector for the {r1,i1,r2,i2} pair record
//   half_e        which half of the head pair is on the output
//   pair_lsb()    bit offset of a field inside a 4*DW pair word
//   clog2()       ceiling log2 for pointer sizing
package fft2_result_serializer_pkg;

    localparam int DW_DEFAULT = 16;

    typedef enum logic [1:0] {
        F_R1 = 2'd0,
        F_I1 = 2'd1,
        F_R2 = 2'd2,
        F_I2 = 2'd3
    } pair_field_e;

    typedef enum logic {
        HALF_FIRST  = 1'b0,
        HALF_SECOND = 1'b1
    } half_e;

    // Record is packed as {r1, i1, r2, i2}, so r1 occupies the top DW bits.
    function automatic int pair_lsb(input pair_field_e f, input int dw);
        return (3 - int'(f)) * dw;
    endfunction

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/fft2_result_serializer_if.sv
// rtl/fft2_result_serializer_if.sv - pair-in / serial-sample-out handshake bundle
// Signals:
//   in_valid, in_ready, r1, i1, r2, i2   parallel butterfly pair input
//   out_valid, out_ready, out_re, out_im, out_last   serial complex sample output
//   overflow   sticky pair-dropped flag
// Modports:
//   master  environment side (drives pairs, accepts samples)
//   slave   serializer side
interface fft2_result_serializer_if
    import fft2_result_serializer_pkg::*;
#(
    parameter int DW = DW_DEFAULT
);
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] r1;
    logic [DW-1:0] i1;
    logic [DW-1:0] r2;
    logic [DW-1:0] i2;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_re;
    logic [DW-1:0] out_im;
    logic          out_last;
    logic          overflow;

    modport master (
        output in_valid, r1, i1, r2, i2, out_ready,
        input  in_ready, out_valid, out_re, out_im, out_last, overflow
    );

    modport slave (
        input  in_valid, r1, i1, r2, i2, out_ready,
        output in_ready, out_valid, out_re, out_im, out_last, overflow
    );
endinterface

// File: rtl/fft2_result_serializer_pair_fifo.sv
// rtl/fft2_result_serializer_pair_fifo.sv - circular DEPTH x 4*DW pair buffer
// Ports:
//   clk, rst         clock, synchronous active-high reset (clears storage too)
//   push, wr_data    write a pair record; ignored while full
//   pop              retire the head record; ignored while empty
//   rd_data          head record (registered storage, no input bypass)
//   full, empty      occupancy flags
module fft_pair_fifo
    import fft2_result_serializer_pkg::*;
#(
    parameter int DW    = DW_DEFAULT,
    parameter int DEPTH = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [4*DW-1:0] wr_data,
    input  logic          pop,
    output logic [4*DW-1:0] rd_data,
    output logic          full,
    output logic          empty
);
    localparam int AW = clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [4*DW-1:0] mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic            do_push;
    logic            do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem[rd_ptr];

    // DEPTH is a power of two, so pointer wrap is plain AW-bit overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fft2_result_serializer.sv
// rtl/fft2_result_serializer.sv - buffers butterfly result pairs and emits them as a serial complex stream
// Ports:
//   clk   system clock, rising edge
//   rst   synchronous active-high reset
//   bus   slave view of fft2_result_serializer_if:
//         in_valid/in_ready/r1/i1/r2/i2 pair input,
//         out_valid/out_ready/out_re/out_im/out_last sample output,
//         overflow sticky drop flag
module fft2_result_serializer
    import fft2_result_serializer_pkg::*;
#(
    parameter int DW    = DW_DEFAULT,
    parameter int DEPTH = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    fft2_result_serializer_if.slave bus
);
    localparam int R1_LSB = pair_lsb(F_R1, DW);
    localparam int I1_LSB = pair_lsb(F_I1, DW);
    localparam int R2_LSB = pair_lsb(F_R2, DW);
    localparam int I2_LSB = pair_lsb(F_I2, DW);

    logic [4*DW-1:0] head;
    logic            full;
    logic            empty;
    logic            accept;
    logic            pop_pair;
    half_e           half;
    logic            overflow_q;

    assign accept   = bus.out_valid && bus.out_ready;
    // The pair is only retired once its second sample has been taken.
    assign pop_pair = accept && (half == HALF_SECOND);

    fft_pair_fifo #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (bus.in_valid),
        .wr_data ({bus.r1, bus.i1, bus.r2, bus.i2}),
        .pop     (pop_pair),
        .rd_data (head),
        .full    (full),
        .empty   (empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            half       <= HALF_FIRST;
            overflow_q <= 1'b0;
        end else begin
            // Full is the pre-edge state: a same-cycle pop does not make room.
            if (bus.in_valid && full) begin
                overflow_q <= 1'b1;
            end
            if (accept) begin
                case (half)
                    HALF_FIRST:  half <= HALF_SECOND;
                    HALF_SECOND: half <= HALF_FIRST;
                    default:     half <= HALF_FIRST;
                endcase
            end
        end
    end

    assign bus.in_ready  = !full;
    assign bus.out_valid = !empty;
    assign bus.out_last  = !empty && (half == HALF_SECOND);
    assign bus.out_re    = (half == HALF_SECOND) ? head[R2_LSB +: DW] : head[R1_LSB +: DW];
    assign bus.out_im    = (half == HALF_SECOND) ? head[I2_LSB +: DW] : head[I1_LSB +: DW];
    assign bus.overflow  = overflow_q;

endmodule

// File: tb/tb_fft2_result_serializer.sv
// tb/tb_fft2_result_serializer.sv - self-checking bench for fft2_result_serializer
module tb_fft2_result_serializer;
    localparam int DW    = 16;
    localparam int DEPTH = 2;

    typedef struct {
        logic [DW-1:0] r1;
        logic [DW-1:0] i1;
        logic [DW-1:0] r2;
        logic [DW-1:0] i2;
    } pair_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    pair_t q[$];
    int    m_half;
    logic  m_ovf;

    fft2_result_serializer_if #(.DW(DW)) bus ();

    fft2_result_serializer #(.DW(DW), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: a queue of whole pairs plus which half is being offered.
    task automatic model_edge();
        int  n;
        bit  room;
        n    = q.size();
        room = (n < DEPTH);
        if (rst) begin
            q.delete();
            m_half = 0;
            m_ovf  = 1'b0;
        end else begin
            if (bus.in_valid && !room) m_ovf = 1'b1;
            if (n > 0 && bus.out_ready) begin
                if (m_half == 0) m_half = 1;
                else begin
                    m_half = 0;
                    void'(q.pop_front());
                end
            end
            if (bus.in_valid && room) begin
                pair_t p;
                p.r1 = bus.r1; p.i1 = bus.i1; p.r2 = bus.r2; p.i2 = bus.i2;
                q.push_back(p);
            end
        end
    endtask

    task automatic check_model(input string tag);
        bit v;
        v = (q.size() > 0);
        chk({tag, ".valid"}, 32'(bus.out_valid), 32'(v));
        chk({tag, ".ready"}, 32'(bus.in_ready), 32'(q.size() < DEPTH));
        chk({tag, ".ovf"},   32'(bus.overflow), 32'(m_ovf));
        chk({tag, ".last"},  32'(bus.out_last), 32'(v && m_half == 1));
        if (v) begin
            chk({tag, ".re"}, 32'(bus.out_re), 32'(m_half == 1 ? q[0].r2 : q[0].r1));
            chk({tag, ".im"}, 32'(bus.out_im), 32'(m_half == 1 ? q[0].i2 : q[0].i1));
        end
    endtask

    task automatic cycle(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_model(tag);
    endtask

    task automatic drive(input logic v, input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input logic [DW-1:0] c, input logic [DW-1:0] d);
        bus.in_valid = v;
        bus.r1 = a; bus.i1 = b; bus.r2 = c; bus.i2 = d;
    endtask

    task automatic idle();
        drive(1'b0, '0, '0, '0, '0);
    endtask

    initial begin
        logic [DW-1:0] h_re;
        logic [DW-1:0] h_im;
        checks = 0;
        errors = 0;
        m_half = 0;
        m_ovf  = 1'b0;
        rst = 1'b1;
        bus.out_ready = 1'b1;
        drive(1'b1, 16'h1111, 16'h2222, 16'h3333, 16'h4444);

        // Reset with in_valid held high.
        cycle("rst0");
        cycle("rst1");
        chk("rst.valid", 32'(bus.out_valid), 32'd0);
        chk("rst.re",    32'(bus.out_re),    32'd0);
        chk("rst.im",    32'(bus.out_im),    32'd0);
        chk("rst.last",  32'(bus.out_last),  32'd0);
        chk("rst.ready", 32'(bus.in_ready),  32'd1);
        chk("rst.ovf",   32'(bus.overflow),  32'd0);
        rst = 1'b0;
        idle();
        cycle("post_rst");
        chk("post_rst.empty", 32'(bus.out_valid), 32'd0);

        // Single pair, out_ready high.
        drive(1'b1, 16'h0010, 16'h0020, 16'h0010, 16'hFFE0);
        cycle("single.push");
        idle();
        chk("single.s0.valid", 32'(bus.out_valid), 32'd1);
        chk("single.s0.re",    32'(bus.out_re),    32'h0010);
        chk("single.s0.im",    32'(bus.out_im),    32'h0020);
        chk("single.s0.last",  32'(bus.out_last),  32'd0);
        cycle("single.s1");
        chk("single.s1.re",    32'(bus.out_re),    32'h0010);
        chk("single.s1.im",    32'(bus.out_im),    32'hFFE0);
        chk("single.s1.last",  32'(bus.out_last),  32'd1);
        cycle("single.done");
        chk("single.done.valid", 32'(bus.out_valid), 32'd0);

        // Back-pressure: first sample must hold for 5 stalled cycles.
        bus.out_ready = 1'b0;
        drive(1'b1, 16'h8001, 16'h7FFF, 16'h1234, 16'hABCD);
        cycle("bp.push");
        idle();
        h_re = bus.out_re;
        h_im = bus.out_im;
        for (int i = 0; i < 5; i++) begin
            chk("bp.hold.re",    32'(bus.out_re),    32'h8001);
            chk("bp.hold.im",    32'(bus.out_im),    32'h7FFF);
            chk("bp.hold.valid", 32'(bus.out_valid), 32'd1);
            chk("bp.hold.stable", 32'({bus.out_re, bus.out_im}), 32'({h_re, h_im}));
            cycle("bp.stall");
        end
        bus.out_ready = 1'b1;
        cycle("bp.s1");
        chk("bp.s1.re", 32'(bus.out_re), 32'h1234);
        chk("bp.s1.im", 32'(bus.out_im), 32'hABCD);
        cycle("bp.done");
        chk("bp.done.valid", 32'(bus.out_valid), 32'd0);

        // Fill and overflow: A, B, C back to back with out_ready low.
        bus.out_ready = 1'b0;
        drive(1'b1, 16'h00A0, 16'h00A1, 16'h00A2, 16'h00A3);
        cycle("fill.A");
        drive(1'b1, 16'h00B0, 16'h00B1, 16'h00B2, 16'h00B3);
        cycle("fill.B");
        chk("fill.full", 32'(bus.in_ready), 32'd0);
        drive(1'b1, 16'h00C0, 16'h00C1, 16'h00C2, 16'h00C3);
        cycle("fill.C");
        idle();
        chk("fill.ovf", 32'(bus.overflow), 32'd1);
        bus.out_ready = 1'b1;
        chk("drain.A0", 32'(bus.out_re), 32'h00A0);
        cycle("drain");
        chk("drain.A1", 32'(bus.out_re), 32'h00A2);
        cycle("drain");
        chk("drain.B0", 32'(bus.out_re), 32'h00B0);
        cycle("drain");
        chk("drain.B1", 32'(bus.out_re), 32'h00B2);
        cycle("drain");
        chk("drain.empty", 32'(bus.out_valid), 32'd0);
        chk("drain.ovf_sticky", 32'(bus.overflow), 32'd1);

        // Simultaneous push and final-half pop.
        drive(1'b1, 16'h0E00, 16'h0E01, 16'h0E02, 16'h0E03);
        cycle("sim.E");
        idle();
        cycle("sim.E0");
        drive(1'b1, 16'h0D00, 16'h0D01, 16'h0D02, 16'h0D03);
        cycle("sim.E1_D");
        idle();
        chk("sim.D.valid", 32'(bus.out_valid), 32'd1);
        chk("sim.D0.re",   32'(bus.out_re),    32'h0D00);
        chk("sim.D0.last", 32'(bus.out_last),  32'd0);
        chk("sim.count1",  32'(bus.in_ready),  32'd1);
        cycle("sim.D1");
        cycle("sim.done");

        // Reset mid-operation with second half pending and overflow set.
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 16'(16'h5000 + i), 16'h5100, 16'h5200, 16'h5300);
            cycle("mid.fill");
        end
        idle();
        bus.out_ready = 1'b1;
        cycle("mid.half");
        bus.out_ready = 1'b0;
        chk("mid.pending", 32'(bus.out_last), 32'd1);
        rst = 1'b1;
        cycle("mid.rst");
        rst = 1'b0;
        chk("mid.rst.valid", 32'(bus.out_valid), 32'd0);
        chk("mid.rst.ovf",   32'(bus.overflow),  32'd0);
        chk("mid.rst.re",    32'(bus.out_re),    32'd0);
        bus.out_ready = 1'b1;
        drive(1'b1, 16'h0F00, 16'h0F01, 16'h0F02, 16'h0F03);
        cycle("mid.push");
        idle();
        chk("mid.after.re",   32'(bus.out_re),   32'h0F00);
        chk("mid.after.last", 32'(bus.out_last), 32'd0);
        cycle("mid.after1");
        cycle("mid.after2");

        // Randomized traffic against the queue model.
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 2) != 0), 16'($urandom), 16'($urandom),
                  16'($urandom), 16'($urandom));
            bus.out_ready = 1'($urandom_range(0, 3) != 0);
            rst = 1'($urandom_range(0, 99) == 0);
            cycle("rand");
        end
        rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
